// File: rtl/skolem_checker_xor_4_3.sv
// Exhaustive checker for a 4-in/3-out Skolem candidate of the XOR relation:
// sweeps x = 0..15 and checks parity(y) == parity(x) after a settle delay.
module skolem_checker_xor_4_3 #(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] x_out,
  input  logic [2:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic       cex_valid,
  output logic [3:0] cex_x,
  output logic [2:0] cex_y
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state_reg;
  logic [3:0] settle_cnt_reg;
  logic       vec_fail;

  assign vec_fail = (^y_in) != (^x_out);
  assign busy     = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
  assign done     = (state_reg == ST_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= 4'd0;
      x_out          <= 4'd0;
      pass           <= 1'b0;
      fail_count     <= 5'd0;
      cex_valid      <= 1'b0;
      cex_x          <= 4'd0;
      cex_y          <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= 4'd0;
            x_out          <= 4'd0;
            pass           <= 1'b0;
            fail_count     <= 5'd0;
            cex_valid      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            settle_cnt_reg <= 4'd0;
            state_reg      <= ST_SAMPLE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (vec_fail) begin
            if (fail_count != 5'd16) begin
              fail_count <= fail_count + 5'd1;
            end
            // Only the first failing vector is kept as the counterexample.
            if (!cex_valid) begin
              cex_valid <= 1'b1;
              cex_x     <= x_out;
              cex_y     <= y_in;
            end
          end
          if ((x_out == 4'd15) || (STOP_ON_FAIL && vec_fail)) begin
            state_reg <= ST_FIN;
          end else begin
            x_out     <= x_out + 4'd1;
            state_reg <= ST_SETTLE;
          end
        end
        default: begin
          pass      <= (fail_count == 5'd0);
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_checker_xor_4_3.sv
// Bench for skolem_checker_xor_4_3: three instances (settle 1, stop-on-fail,
// settle 3) driven by a shared candidate lookup table, compared against a sweep model.
module tb_skolem_checker_xor_4_3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_o = 1'b0;

  logic [3:0] x_a, x_b, x_c;
  logic [2:0] y_a, y_b, y_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [4:0] fail_a, fail_b, fail_c;
  logic       cexv_a, cexv_b, cexv_c;
  logic [3:0] cexx_a, cexx_b, cexx_c;
  logic [2:0] cexy_a, cexy_b, cexy_c;

  logic [2:0] lut [16];
  bit         delayed = 1'b0;
  logic [3:0] xa_d1, xa_d2, xc_d1, xc_d2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Delayed candidate: correct parity, but two clocks late.
  always @(posedge clk) begin
    xa_d1 <= x_a;
    xa_d2 <= xa_d1;
    xc_d1 <= x_c;
    xc_d2 <= xc_d1;
  end

  assign y_a = delayed ? {2'b00, ^xa_d2} : lut[x_a];
  assign y_c = delayed ? {2'b00, ^xc_d2} : lut[x_c];
  assign y_b = lut[x_b];

  skolem_checker_xor_4_3 #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x_out(x_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fail_a),
    .cex_valid(cexv_a), .cex_x(cexx_a), .cex_y(cexy_a));

  skolem_checker_xor_4_3 #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_o), .x_out(x_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fail_b),
    .cex_valid(cexv_b), .cex_x(cexx_b), .cex_y(cexy_b));

  skolem_checker_xor_4_3 #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start_o), .x_out(x_c), .y_in(y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fail_c),
    .cex_valid(cexv_c), .cex_x(cexx_c), .cex_y(cexy_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk vectors 0..nvec-1, a vector fails when the popcount parities differ.
  task automatic model(input bit stop, input int nvec, output int fails, output int first);
    fails = 0;
    first = -1;
    for (int v = 0; v < nvec; v++) begin
      logic [3:0] xv;
      xv = 4'(v);
      if (($countones(lut[v]) % 2) != ($countones(xv) % 2)) begin
        fails++;
        if (first < 0) first = v;
        if (stop) break;
      end
    end
  endtask

  task automatic set_lut_correct();
    for (int v = 0; v < 16; v++) lut[v] = {2'b00, 1'(($countones(4'(v))) % 2)};
  endtask

  task automatic run_sweep(input bit glitch, input string tag);
    int fa, ffa, fb, ffb, fl, ffl;
    int lat_a, lat_b, lat_c, cnt_a, cnt_b, cnt_c, exp_lat_b;
    model(1'b0, 16, fa, ffa);
    model(1'b1, 16, fb, ffb);
    model(1'b0, 5, fl, ffl);
    exp_lat_b = (ffb >= 0) ? 2 * (ffb + 1) : 32;
    lat_a = 0; lat_b = 0; lat_c = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
    @(negedge clk); start_a = 1'b1; start_o = 1'b1;
    @(negedge clk); start_a = 1'b0; start_o = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (n == 1) begin
        check({tag, "/busy_early"}, busy_a, 1);
        check({tag, "/pass_low_in_sweep"}, pass_a, 0);
      end
      if (n == 10 && !delayed) check({tag, "/live_fail_count"}, fail_a, fl);
      if (glitch && n == 10) start_a = 1'b1;
      if (done_a) begin cnt_a++; if (lat_a == 0) lat_a = n; end
      if (done_b) begin cnt_b++; if (lat_b == 0) lat_b = n; end
      if (done_c) begin cnt_c++; if (lat_c == 0) lat_c = n; end
    end
    check({tag, "/lat_a"}, lat_a, 32);
    check({tag, "/done_count_a"}, cnt_a, 1);
    check({tag, "/lat_c"}, lat_c, 64);
    check({tag, "/done_count_c"}, cnt_c, 1);
    check({tag, "/lat_b"}, lat_b, exp_lat_b);
    check({tag, "/done_count_b"}, cnt_b, 1);
    check({tag, "/fail_b"}, fail_b, fb);
    check({tag, "/pass_b"}, pass_b, (fb == 0));
    check({tag, "/cexv_b"}, cexv_b, (fb > 0));
    if (fb > 0) check({tag, "/cexx_b"}, cexx_b, ffb);
    if (!delayed) begin
      check({tag, "/fail_a"}, fail_a, fa);
      check({tag, "/pass_a"}, pass_a, (fa == 0));
      check({tag, "/cexv_a"}, cexv_a, (fa > 0));
      check({tag, "/fail_c"}, fail_c, fa);
      check({tag, "/pass_c"}, pass_c, (fa == 0));
      if (fa > 0) begin
        check({tag, "/cexx_a"}, cexx_a, ffa);
        check({tag, "/cexy_a"}, cexy_a, lut[ffa]);
        check({tag, "/cexx_c"}, cexx_c, ffa);
      end
    end else begin
      check({tag, "/pass_a_delayed"}, pass_a, 0);
      check({tag, "/pass_c_delayed"}, pass_c, 1);
      check({tag, "/fail_c_delayed"}, fail_c, 0);
      check({tag, "/cexv_c_delayed"}, cexv_c, 0);
    end
    $display("sweep %s: fail_a=%0d pass_a=%0d fail_b=%0d lat_b=%0d", tag, fail_a, pass_a, fail_b, lat_b);
  endtask

  initial begin
    int n, dcnt;
    set_lut_correct();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/a", {x_a, busy_a, done_a, pass_a, fail_a, cexv_a, cexx_a, cexy_a}, 0);
    check("reset/b", {x_b, busy_b, done_b, pass_b, fail_b, cexv_b, cexx_b, cexy_b}, 0);
    check("reset/c", {x_c, busy_c, done_c, pass_c, fail_c, cexv_c, cexx_c, cexy_c}, 0);
    rst = 1'b0;

    set_lut_correct();
    run_sweep(1'b0, "correct");

    for (int v = 0; v < 16; v++) lut[v] = 3'b000;
    run_sweep(1'b1, "const0");
    check("const0/cex_x_a", cexx_a, 1);
    check("const0/fail_a_8", fail_a, 8);

    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 16; v++)
        lut[v] = ($urandom_range(0, 1) == 0) ? {2'b00, 1'(($countones(4'(v))) % 2)}
                                             : 3'($urandom_range(0, 7));
      run_sweep(r[0], $sformatf("rand%0d", r));
    end

    set_lut_correct();
    delayed = 1'b1;
    run_sweep(1'b0, "delayed");
    delayed = 1'b0;

    // Reset in the middle of a sweep
    for (int v = 0; v < 16; v++) lut[v] = 3'b000;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (x_a != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("midrst/reach7", x_a, 7);
    check("midrst/fail_before", fail_a, 3);
    rst = 1'b1;
    #1;
    check("midrst/outputs_zero", {x_a, busy_a, done_a, pass_a, fail_a, cexv_a, cexx_a, cexy_a}, 0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    check("midrst/no_done", dcnt, 0);
    for (int v = 0; v < 16; v++) lut[v] = 3'($urandom_range(0, 7));
    run_sweep(1'b0, "after_rst");

    // start held high: back-to-back sweeps
    set_lut_correct();
    @(negedge clk); start_a = 1'b1;
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b/first_done", done_a, 1);
    @(negedge clk);
    check("b2b/idle_gap", {busy_a, done_a}, 0);
    @(negedge clk);
    check("b2b/restart_busy", busy_a, 1);
    check("b2b/restart_x0", x_a, 0);
    n = 2;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    check("b2b/second_done_gap", n, 34);
    check("b2b/pass", fail_a, 0);
    repeat (40) @(negedge clk);
    check("b2b/stopped", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
